// File: rtl/csh_sweep_ctl.sv
// Cache directory sweep sequencer: walks every set, invalidating and/or writing back
// written ways through a req/ack handshake, yielding to the CPU only between sets.
module csh_sweep_ctl #(
  parameter int SET_BITS   = 7,
  parameter int WAYS       = 4,
  parameter int WBCNT_BITS = 8
) (
  input  logic                    clk_csh_h,
  input  logic                    reset_h,
  input  logic                    sweep_start_h,
  input  logic [1:0]              sweep_mode_h,
  input  logic                    cpu_hold_h,
  input  logic [WAYS-1:0]         way_valid_h,
  input  logic [WAYS-1:0]         way_written_h,
  input  logic                    wb_ack_h,
  output logic                    sweep_busy_h,
  output logic                    sweep_done_h,
  output logic [SET_BITS-1:0]     csh_sweep_adr_h,
  output logic                    wb_req_h,
  output logic [$clog2(WAYS)-1:0] wb_way_h,
  output logic                    csh_val_wr_pulse_l,
  output logic                    csh_val_sel_all_h,
  output logic                    csh_val_wr_data_h,
  output logic [WBCNT_BITS-1:0]   wb_count_h
);

  localparam int WAY_W = $clog2(WAYS);
  localparam logic [1:0] MODE_INV = 2'd0;
  localparam logic [1:0] MODE_WB  = 2'd1;
  localparam logic [1:0] MODE_NOP = 2'd3;
  localparam logic [SET_BITS-1:0] ADR_MAX = '1;

  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, INVAL, NEXT, DONE} state_t;

  state_t          state;
  state_t          nxt;
  logic [1:0]      mode_q;
  logic [WAYS-1:0] pend;

  function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = WAY_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [WBCNT_BITS-1:0] sat_inc(input logic [WBCNT_BITS-1:0] c);
    return (&c) ? c : c + WBCNT_BITS'(1);
  endfunction

  always_ff @(posedge clk_csh_h or posedge reset_h) begin
    if (reset_h) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (sweep_start_h) nxt = (sweep_mode_h == MODE_NOP) ? DONE : READ;
      READ:  nxt = CHECK;
      CHECK: begin
        if (pend != '0)            nxt = WB;
        else if (mode_q == MODE_WB) nxt = NEXT;
        else                       nxt = INVAL;
      end
      WB:    if (wb_ack_h) nxt = CHECK;
      INVAL: nxt = NEXT;
      NEXT:  if (!cpu_hold_h) nxt = (csh_sweep_adr_h == ADR_MAX) ? DONE : READ;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_csh_h or posedge reset_h) begin
    if (reset_h) begin
      mode_q             <= MODE_INV;
      pend               <= '0;
      csh_sweep_adr_h    <= '0;
      wb_count_h         <= '0;
      wb_way_h           <= '0;
      sweep_busy_h       <= 1'b0;
      sweep_done_h       <= 1'b0;
      wb_req_h           <= 1'b0;
      csh_val_wr_pulse_l <= 1'b1;
      csh_val_sel_all_h  <= 1'b0;
    end else begin
      sweep_busy_h       <= (nxt != IDLE);
      sweep_done_h       <= (nxt == DONE);
      wb_req_h           <= (nxt == WB);
      csh_val_wr_pulse_l <= (nxt != INVAL);
      csh_val_sel_all_h  <= (nxt == INVAL);
      case (state)
        IDLE: begin
          if (sweep_start_h) begin
            mode_q          <= sweep_mode_h;
            csh_sweep_adr_h <= '0;
            wb_count_h      <= '0;
          end
        end
        READ: pend <= (mode_q == MODE_INV) ? '0 : (way_written_h & way_valid_h);
        CHECK: begin
          if (pend != '0) wb_way_h <= lowest_way(pend);
        end
        WB: begin
          if (wb_ack_h) begin
            pend       <= pend & ~(WAYS'(1) << wb_way_h);
            wb_count_h <= sat_inc(wb_count_h);
          end
        end
        NEXT: begin
          if (!cpu_hold_h && csh_sweep_adr_h != ADR_MAX)
            csh_sweep_adr_h <= csh_sweep_adr_h + SET_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // The valid write always clears the selected ways.
  assign csh_val_wr_data_h = 1'b0;

endmodule

// File: tb/tb_csh_sweep_ctl.sv
`timescale 1ns/1ps
// Bench for csh_sweep_ctl: a vector table, hand-written hold/reset sequences and
// randomized sweeps, all compared against a per-set event model of the sweep rules.
module tb_csh_sweep_ctl;
  localparam int NSETS  = 128;
  localparam int EV_WB  = 32'h0001_0000;
  localparam int EV_INV = 32'h0002_0000;

  logic       clk, rst, start, hold, ack;
  logic [1:0] mode;
  logic [3:0] vld, wrt;
  logic       busy, done, req, pulse_l, sel_all, wr_data;
  logic [6:0] adr;
  logic [1:0] way;
  logic [7:0] cnt;

  logic [3:0] vmem [NSETS];
  logic [3:0] wmem [NSETS];
  assign vld = vmem[adr];
  assign wrt = wmem[adr];

  csh_sweep_ctl dut (
    .clk_csh_h(clk), .reset_h(rst), .sweep_start_h(start), .sweep_mode_h(mode),
    .cpu_hold_h(hold), .way_valid_h(vld), .way_written_h(wrt), .wb_ack_h(ack),
    .sweep_busy_h(busy), .sweep_done_h(done), .csh_sweep_adr_h(adr), .wb_req_h(req),
    .wb_way_h(way), .csh_val_wr_pulse_l(pulse_l), .csh_val_sel_all_h(sel_all),
    .csh_val_wr_data_h(wr_data), .wb_count_h(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // sweep-run controls and observations
  int lat, hold_pol, noise, restart_at, reset_at;
  int done_cyc, done_cnt, ack_cnt, inv_cnt, busy_cyc, bad_strobe, win_bad, win_pulses;
  logic [31:0] busy_after;
  bit reset_hit, timeout;
  int ev_q[$];

  task automatic fill_mem(input int pset, input logic [3:0] v, input logic [3:0] w);
    for (int s = 0; s < NSETS; s++) begin
      vmem[s] = (pset == -1 || pset == s) ? v : 4'h0;
      wmem[s] = (pset == -1 || pset == s) ? w : 4'h0;
    end
  endtask

  task automatic run_sweep(input logic [1:0] m);
    int cyc, rcnt, hold_cnt;
    bit hold_started, restarted, fin;
    ev_q.delete();
    done_cyc = -1; done_cnt = 0; ack_cnt = 0; inv_cnt = 0; busy_cyc = 0; bad_strobe = 0;
    win_bad = 0; win_pulses = 0; busy_after = '1; reset_hit = 0; timeout = 0;
    cyc = 0; rcnt = 0; hold_cnt = 0; hold_started = 0; restarted = 0; fin = 0;
    @(negedge clk);
    mode = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    mode = 2'($urandom);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (sel_all !== !pulse_l || wr_data !== 1'b0) bad_strobe++;
      if (!pulse_l) begin
        ev_q.push_back(EV_INV + int'(adr));
        inv_cnt++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = {31'b0, busy};
        fin = 1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (req) begin
        ack = (rcnt >= lat);
        rcnt++;
        if (ack) begin
          ev_q.push_back(EV_WB + int'(adr) * 16 + int'(way));
          ack_cnt++;
        end
      end else begin
        rcnt = 0;
        ack = (noise != 0) ? ($urandom_range(2) == 0) : 1'b0;
      end
      if (hold_pol == 1) begin
        if (!hold_started && adr == 7'd10) begin
          hold_started = 1;
          hold_cnt = 13;
        end
        if (hold_cnt > 0) begin
          hold = 1'b1;
          hold_cnt--;
          if (adr != 7'd10) win_bad++;
          if (!pulse_l) win_pulses++;
        end else hold = 1'b0;
      end else if (hold_pol == 2) hold = ($urandom_range(2) == 0);
      else hold = 1'b0;
      if (restart_at >= 0 && !restarted && adr == 7'(restart_at)) begin
        start = 1'b1; mode = 2'd3; restarted = 1;
      end else start = 1'b0;
      if (reset_at >= 0 && adr == 7'(reset_at)) begin
        chk("pre_reset_done_pulses", done_cnt, 0);
        chk("pre_reset_inv_events", ev_q.size(), reset_at);
        #2 rst = 1'b1;
        #1;
        chk("rst_adr", {25'b0, adr}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_pulse_l", {31'b0, pulse_l}, 1);
        chk("rst_wb_req", {31'b0, req}, 0);
        chk("rst_sel_all", {31'b0, sel_all}, 0);
        chk("rst_done", {31'b0, done}, 0);
        reset_hit = 1;
        fin = 1;
      end
      if (cyc > 8000) begin
        timeout = 1;
        fin = 1;
      end
    end
    ack = 1'b0; hold = 1'b0; start = 1'b0;
    if (timeout) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Reference: per set, written&valid ways ascending (modes 1,2), then one clear (modes 0,2).
  task automatic check_model(input string tag, input logic [1:0] m);
    int exp_q[$];
    int nwb, n, idx;
    nwb = 0;
    for (int s = 0; s < NSETS; s++) begin
      if (m == 2'd1 || m == 2'd2)
        for (int w = 0; w < 4; w++)
          if (vmem[s][w] && wmem[s][w]) begin
            exp_q.push_back(EV_WB + s * 16 + w);
            nwb++;
          end
      if (m == 2'd0 || m == 2'd2) exp_q.push_back(EV_INV + s);
    end
    chk({tag, "_ev_count"}, ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    idx = n;
    for (int i = 0; i < n; i++)
      if (ev_q[i] != exp_q[i]) begin
        idx = i;
        break;
      end
    if (idx < n) $display("  %s event %0d got %h expected %h", tag, idx, ev_q[idx], exp_q[idx]);
    chk({tag, "_ev_first_diff"}, idx, n);
    chk({tag, "_wb_count"}, {24'b0, cnt}, (nwb > 255) ? 255 : nwb);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_after_done"}, busy_after, 0);
    chk({tag, "_strobe_fields"}, bad_strobe, 0);
    chk({tag, "_timeout"}, {31'b0, timeout}, 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         pset;
    logic [3:0] v;
    logic [3:0] w;
    int         lat;
    int         exp_done;
    int         exp_cnt;
    int         exp_inv;
    int         exp_wb;
  } vec_t;

  vec_t vt[8];
  string tag;
  logic [1:0] rm;

  initial begin
    vt[0] = '{2'd0, -1, 4'h0, 4'h0, 0,  513,   0, 128,   0};
    vt[1] = '{2'd0, -1, 4'hF, 4'hF, 0,  513,   0, 128,   0};
    vt[2] = '{2'd1,  5, 4'hF, 4'hA, 2,  393,   2,   0,   2};
    vt[3] = '{2'd2,  0, 4'h1, 4'h1, 0,  515,   1, 128,   1};
    vt[4] = '{2'd3, -2, 4'h0, 4'h0, 0,    1,   0,   0,   0};
    vt[5] = '{2'd1, -1, 4'hF, 4'hF, 0, 1409, 255,   0, 512};
    vt[6] = '{2'd2,  7, 4'hC, 4'h6, 1,  516,   1, 128,   1};
    vt[7] = '{2'd1, -2, 4'h0, 4'h0, 0,  385,   0,   0,   0};

    rst = 1'b0; start = 1'b0; mode = 2'd0; hold = 1'b0; ack = 1'b0;
    fill_mem(-2, 4'h0, 4'h0);
    #1 rst = 1'b1;
    #1;
    chk("reset_adr", {25'b0, adr}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_wb_req", {31'b0, req}, 0);
    chk("reset_wb_way", {30'b0, way}, 0);
    chk("reset_pulse_l", {31'b0, pulse_l}, 1);
    chk("reset_sel_all", {31'b0, sel_all}, 0);
    chk("reset_wr_data", {31'b0, wr_data}, 0);
    chk("reset_wb_count", {24'b0, cnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    lat = 0; hold_pol = 0; noise = 0; restart_at = -1; reset_at = -1;
    for (int i = 0; i < 8; i++) begin
      fill_mem(vt[i].pset, vt[i].v, vt[i].w);
      lat = vt[i].lat;
      run_sweep(vt[i].mode);
      tag = $sformatf("vec%0d", i);
      chk({tag, "_done_cycle"}, done_cyc, vt[i].exp_done);
      chk({tag, "_busy_cycles"}, busy_cyc, vt[i].exp_done);
      chk({tag, "_inv_pulses"}, inv_cnt, vt[i].exp_inv);
      chk({tag, "_wb_acks"}, ack_cnt, vt[i].exp_wb);
      chk({tag, "_wb_count"}, {24'b0, cnt}, vt[i].exp_cnt);
      check_model(tag, vt[i].mode);
      repeat (3) @(negedge clk);
      chk({tag, "_wb_count_held"}, {24'b0, cnt}, vt[i].exp_cnt);
    end

    // CPU hold at set 10: NEXT stalls for 10 cycles
    fill_mem(-2, 4'h0, 4'h0);
    lat = 0; hold_pol = 1;
    run_sweep(2'd0);
    chk("hold_done_cycle", done_cyc, 523);
    chk("hold_adr_moved", win_bad, 0);
    chk("hold_window_pulses", win_pulses, 1);
    check_model("hold", 2'd0);
    hold_pol = 0;

    // ignored second start at set 20, reset at set 40, then a fresh sweep
    restart_at = 20; reset_at = 40;
    run_sweep(2'd0);
    chk("reset_reached", {31'b0, reset_hit}, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'b0, busy}, 0);
    chk("post_reset_adr", {25'b0, adr}, 0);
    restart_at = -1; reset_at = -1;
    run_sweep(2'd0);
    chk("after_reset_done_cycle", done_cyc, 513);
    check_model("after_reset", 2'd0);

    // randomized sweeps with random holds, latencies and stray acks
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < NSETS; s++) begin
        vmem[s] = 4'($urandom);
        wmem[s] = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      end
      rm = 2'($urandom_range(2));
      lat = $urandom_range(3);
      hold_pol = 2; noise = 1;
      run_sweep(rm);
      check_model($sformatf("rand%0d_m%0d", r, rm), rm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csh_sweep_ctl.md
Name: csh_sweep_ctl

Overview:
- Sequencer that sweeps the 4-way cache directory set by set (128 sets, 7-bit set address).
- Performs three kinds of sweep: invalidate, writeback of written ways, or writeback followed by invalidate.
- Drives the set address, the valid-write controls and a writeback request handshake toward the memory box.
- Yields to CPU cache traffic only at set boundaries.

Parameters:
- SET_BITS, 7, width of the set address; swept range is 0..2^SET_BITS-1.
- WAYS, 4, number of directory ways; way index width is 2.
- WBCNT_BITS, 8, width of the saturating writeback counter.

Ports:
- clk_csh_h  in  1  cache clock; all state changes on its rising edge.
- reset_h  in  1  reset, asynchronous and active-high.
- sweep_start_h  in  1  start pulse; sampled only in IDLE.
- sweep_mode_h  in  2  sweep mode: 0 = invalidate, 1 = writeback only, 2 = writeback then invalidate, 3 = no-op.
- cpu_hold_h  in  1  CPU request pending; stalls the sweep at the next set boundary.
- way_valid_h  in  WAYS  per-way valid status for the addressed set.
- way_written_h  in  WAYS  per-way written status for the addressed set.
- wb_ack_h  in  1  memory box has accepted the writeback.
- sweep_busy_h  out  1  high whenever the FSM is not in IDLE.
- sweep_done_h  out  1  one-cycle pulse at the end of a sweep.
- csh_sweep_adr_h  out  SET_BITS  current set address.
- wb_req_h  out  1  writeback request.
- wb_way_h  out  2  way to write back.
- csh_val_wr_pulse_l  out  1  active-low valid write strobe.
- csh_val_sel_all_h  out  1  select all ways for the valid write.
- csh_val_wr_data_h  out  1  valid write data; always 0, so the write clears.
- wb_count_h  out  WBCNT_BITS  saturating count of acknowledged writebacks in the current sweep.

Behaviour:
- Reset values: FSM = IDLE; adr = 0; wb_count = 0; busy = 0; done = 0; wb_req = 0; wb_way = 0; val_wr_pulse_l = 1; sel_all = 0; wr_data = 0.
- Reset asserted mid-sweep: all state and outputs return to the reset values immediately (asynchronously). No partial pulse continues after reset.
- All outputs are registered.
- FSM states: IDLE, READ, CHECK, WB, INVAL, NEXT, DONE.
  - IDLE: when start = 1, latch mode, clear adr and wb_count.
    - Mode 3: go to DONE.
    - Otherwise: go to READ.
  - READ: one settle cycle. At the end of the cycle, latch pend = way_written & way_valid when mode is 1 or 2; pend = 0 when mode is 0. Go to CHECK.
  - CHECK:
    - pend != 0: wb_way = index of the lowest set bit of pend; go to WB.
    - pend == 0 and mode is 0 or 2: go to INVAL.
    - pend == 0 and mode is 1: go to NEXT.
  - WB: wb_req = 1 and wb_way stay stable until wb_ack is seen.
    - On ack: clear that bit in pend; wb_count += 1, saturating at all-ones; wb_req = 0 in the following cycle; go to CHECK.
    - wb_ack seen in any other state is ignored.
    - Ack in the first WB cycle is legal.
  - INVAL: val_wr_pulse_l = 0 and sel_all = 1 for exactly one cycle. Go to NEXT.
  - NEXT:
    - cpu_hold = 1: remain in NEXT with adr unchanged.
    - Else if adr == max: go to DONE.
    - Else: adr += 1; go to READ.
    - adr never wraps during a sweep.
  - DONE: done = 1 for one cycle; busy = 1 during this cycle. Go to IDLE.
- Busy: busy = 1 in every state except IDLE.
- Latency with no writebacks: 4 cycles per set in modes 0 and 2, 3 cycles per set in mode 1.
  - Mode 0 full sweep: start edge → done pulse in cycle 513; busy deasserts in cycle 514.
- Start with busy = 1: ignored. Mode changes mid-sweep: ignored.
- cpu_hold outside NEXT: no effect.
- Each way with a pending writeback costs 1 CHECK cycle plus at least 1 WB cycle.
- wb_count holds its value after done until the next start.

Test Plan:
- Mode 0, all ways invalid, no hold → exactly 128 val_wr_pulse_l lows at adr 0..127 in order, each with sel_all = 1 and wr_data = 0. Done pulse 513 cycles after the start edge. wb_count = 0.
- Mode 1, set 5 has valid = 1111, written = 1010, ack returned 2 cycles after each req → wb_req at adr 5 with way 1, then way 3. No valid pulses. Final wb_count = 2.
- Mode 2, set 0 has valid = 0001, written = 0001, ack returned in the same cycle as req → one writeback of way 0, then a valid pulse at adr 0, then READ of set 1.
- Mode 0, cpu_hold = 1 for 10 cycles when adr = 10 reaches NEXT → adr stays 10 and no pulses occur during the hold. Sweep resumes at adr 11 and completes normally.
- Second start during busy, and reset_h asserted at adr 40 mid-sweep → the second start is ignored. After reset: adr = 0, busy = 0, val_wr_pulse_l = 1, wb_req = 0 at once. A new start sweeps again from 0.
- Mode 3 → busy for 1 cycle, done 1 cycle after the start edge, no other activity. 300 acks in mode 1 → wb_count saturates at 255.
